// File: rtl/interrupt_pending_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_pending_controller_pkg
//  Description : Shared constants and helpers for the interrupt pending
//                controller: config map, FSM encodings, priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package interrupt_pending_controller_pkg;

    localparam int IRQ_NUM_SRC = 6;
    localparam int IRQ_IDX_W   = 3;
    localparam int IRQ_STATE_W = 1;

    // Config register addresses
    localparam logic [1:0] IRQ_PENDING = 2'd0;
    localparam logic [1:0] IRQ_MASK    = 2'd1;
    localparam logic [1:0] IRQ_MODE    = 2'd2;
    localparam logic [1:0] IRQ_STATUS  = 2'd3;

    // Service FSM encodings
    localparam logic [IRQ_STATE_W-1:0] IRQ_IDLE    = 1'b0;
    localparam logic [IRQ_STATE_W-1:0] IRQ_SERVICE = 1'b1;

    // Index of the highest set bit; bit 5 (IP7) has the highest priority
    function automatic logic [IRQ_IDX_W-1:0] irq_prio_idx(input logic [IRQ_NUM_SRC-1:0] v);
        irq_prio_idx = '0;
        for (int i = 0; i < IRQ_NUM_SRC; i++) begin
            if (v[i]) begin
                irq_prio_idx = IRQ_IDX_W'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_pending_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_pending_controller_if
//  Description : Word-addressed configuration bus of the interrupt pending
//                controller. Read data is combinational from the address.
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_pending_controller_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata, input  cfg_rdata);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata, output cfg_rdata);
endinterface
`default_nettype wire

// File: rtl/interrupt_pending_controller_irq_synchroniser.sv
`default_nettype none
// ============================================================================
//  Module      : irq_synchroniser
//  Description : Per-bit multi-flop synchroniser for raw interrupt lines,
//                plus a one-cycle history register and rising-edge detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_synchroniser #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] async_i,
    output logic      [WIDTH-1:0] sync_o,
    output logic      [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    // Flop chain for metastability settling, then one cycle of history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign sync_o = stage_q[STAGES-1];
    assign rise_o = stage_q[STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/interrupt_pending_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_pending_controller
//  Description : Synchronises six external interrupt lines, holds edge/level
//                pending, mask and mode state, drives Cause.IP[15:10] and
//                blocks the source in service until eret.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_pending_controller
    import interrupt_pending_controller_pkg::*;
#(
    parameter int NUM_SRC     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [NUM_SRC-1:0]   hw_irq_in,
    interrupt_pending_controller_if.slave cfg,
    input  wire logic                 int_taken,
    input  wire logic                 eret,
    output logic      [NUM_SRC-1:0]   interrupt_request,
    output logic                      in_service
);

    logic [NUM_SRC-1:0]     w_sync, w_rise;
    logic [NUM_SRC-1:0]     pend_q, pend_d;
    logic [NUM_SRC-1:0]     mask_q, mask_d;
    logic [NUM_SRC-1:0]     mode_q, mode_d;
    logic [IRQ_STATE_W-1:0] state_q, state_d;
    logic [IRQ_IDX_W-1:0]   svc_idx_q, svc_idx_d;

    logic [NUM_SRC-1:0]     w_eff_pend, w_cand, w_svc_onehot, w_cap_clr, w_w1c;
    logic [IRQ_IDX_W-1:0]   w_cap_idx;
    logic                   w_capture;
    logic                   w_unused_wdata;

    irq_synchroniser #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (hw_irq_in),
        .sync_o  (w_sync),
        .rise_o  (w_rise)
    );

    // Level sources follow the line; edge sources use the latched bit
    assign w_eff_pend   = (mode_q & pend_q) | (~mode_q & w_sync);
    assign w_svc_onehot = (state_q == IRQ_SERVICE) ? (NUM_SRC'(1) << svc_idx_q) : '0;
    assign interrupt_request = w_eff_pend & mask_q & ~w_svc_onehot;

    // Capture candidates ignore the in-service block: a capture only happens
    // from IDLE or in the eret cycle, where the block is being lifted anyway
    assign w_cand    = w_eff_pend & mask_q;
    assign w_cap_idx = irq_prio_idx(w_cand);

    // Service state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IRQ_IDLE;
            svc_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            svc_idx_q <= svc_idx_d;
        end
    end

    // Next state: eret resolves first, then int_taken from the resulting state
    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        if ((state_q == IRQ_SERVICE) && eret) begin
            state_d = IRQ_IDLE;
        end
        if (((state_q == IRQ_IDLE) || eret) && int_taken && (|w_cand)) begin
            state_d   = IRQ_SERVICE;
            w_capture = 1'b1;
        end
    end

    // FSM outputs: service flag and captured source index
    always_comb begin
        in_service = (state_q == IRQ_SERVICE);
        svc_idx_d  = w_capture ? w_cap_idx : svc_idx_q;
        w_cap_clr  = w_capture ? (NUM_SRC'(1) << w_cap_idx) : '0;
    end

    // Pending/mask/mode next state; a new rise beats any clear
    always_comb begin
        w_w1c  = (cfg.cfg_we && (cfg.cfg_addr == IRQ_PENDING)) ? cfg.cfg_wdata[NUM_SRC-1:0] : '0;
        pend_d = mode_q & (w_rise | (pend_q & ~(w_w1c | w_cap_clr)));
        mask_d = mask_q;
        mode_d = mode_q;
        if (cfg.cfg_we && (cfg.cfg_addr == IRQ_MASK)) begin
            mask_d = cfg.cfg_wdata[NUM_SRC-1:0];
        end
        if (cfg.cfg_we && (cfg.cfg_addr == IRQ_MODE)) begin
            mode_d = cfg.cfg_wdata[NUM_SRC-1:0];
        end
    end

    // Configuration and pending registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
        end
    end

    // Combinational read-back mux
    always_comb begin
        cfg.cfg_rdata = '0;
        case (cfg.cfg_addr)
            IRQ_PENDING: cfg.cfg_rdata = {{(32-NUM_SRC){1'b0}}, w_eff_pend};
            IRQ_MASK:    cfg.cfg_rdata = {{(32-NUM_SRC){1'b0}}, mask_q};
            IRQ_MODE:    cfg.cfg_rdata = {{(32-NUM_SRC){1'b0}}, mode_q};
            default:     cfg.cfg_rdata = {23'b0, in_service, 5'b0, svc_idx_q};
        endcase
    end

    assign w_unused_wdata = ^cfg.cfg_wdata[31:NUM_SRC];

endmodule
`default_nettype wire
